// File: rtl/morse_pkg.sv
// Shared encodings and FSM states for the Morse letter capture front end.
package morse_pkg;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS,
      ST_GAP,
      ST_COMMIT,
      ST_WAIT_WORD
   } state_t;

   // Word-space code is all ones over 2*max_symbols bits; callers truncate.
   function automatic logic [63:0] space_code(input int unsigned max_symbols);
      return (64'd1 << (2 * max_symbols)) - 64'd1;
   endfunction

endpackage

// File: rtl/morse_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and full/empty flags.
module morse_fifo #(
   parameter int DATA_W = 10,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [DATA_W-1:0]        i_wr_data,
   output logic [DATA_W-1:0]        o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [AW:0]       r_count;
   logic              w_pop;
   logic              w_push;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   // A pop in the same cycle frees the slot, so a push on full still lands.
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count   = r_count;

endmodule

// File: rtl/morse_letter_capture.sv
// Times debounced key presses into dots/dashes and frames letters by silence into a FIFO.
// Optional word-space emission after a long silence is enabled by MORSE_WORD_GAP_EN.
module morse_letter_capture
   import morse_pkg::*;
#(
   parameter int TICK_DIV         = 100000,
   parameter int DOT_MAX_TICKS    = 200,
   parameter int LETTER_GAP_TICKS = 600,
   parameter int WORD_GAP_TICKS   = 1400,
   parameter int MAX_SYMBOLS      = 5,
   parameter int FIFO_DEPTH       = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          key,
   input  logic                          flush,
   input  logic                          rd_en,
   output logic [2*MAX_SYMBOLS-1:0]      rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [2*MAX_SYMBOLS-1:0]      live_code,
   output logic                          overflow,
   output logic                          symbol_err
);

   localparam int CODE_W = 2 * MAX_SYMBOLS;
   localparam int PS_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MAX_T  = (WORD_GAP_TICKS > LETTER_GAP_TICKS) ?
                           ((WORD_GAP_TICKS > DOT_MAX_TICKS) ? WORD_GAP_TICKS : DOT_MAX_TICKS) :
                           ((LETTER_GAP_TICKS > DOT_MAX_TICKS) ? LETTER_GAP_TICKS : DOT_MAX_TICKS);
   localparam int CNT_W  = $clog2(MAX_T + 1) + 1;
   localparam int SC_W   = $clog2(MAX_SYMBOLS + 1);

   state_t             r_state;
   logic               r_key;
   logic [PS_W-1:0]    r_presc;
   logic [CNT_W-1:0]   r_press_cnt;
   logic [CNT_W-1:0]   r_gap_cnt;
   logic [SC_W-1:0]    r_sym_cnt;
   logic               r_err_flag;
   logic [CODE_W-1:0]  r_live_code;
   logic               r_overflow;
   logic               r_symbol_err;

   logic               w_tick;
   logic               w_push;
   logic [CODE_W-1:0]  w_push_data;
   logic               w_full;
   logic               w_empty;
   logic               w_dropped;
   logic [1:0]         w_sym;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   function automatic logic [CODE_W-1:0] f_append(input logic [CODE_W-1:0] code,
                                                  input logic [SC_W-1:0]   idx,
                                                  input logic [1:0]        sym);
      logic [CODE_W-1:0] res;
      res = code;
      for (int i = 0; i < MAX_SYMBOLS; i++) begin
         if (idx == SC_W'(i)) res[CODE_W-1-2*i -: 2] = sym;
      end
      return res;
   endfunction

   assign w_tick = (r_presc == PS_W'(TICK_DIV - 1));
   assign w_sym  = (r_press_cnt <= CNT_W'(DOT_MAX_TICKS)) ? SYM_DOT : SYM_DASH;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_key   <= 1'b0;
         r_presc <= '0;
      end else begin
         r_key   <= key;
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
   end

   always_comb begin
      w_push      = 1'b0;
      w_push_data = r_live_code;
      if (r_state == ST_COMMIT && !r_err_flag) w_push = 1'b1;
`ifdef MORSE_WORD_GAP_EN
      if (r_state == ST_WAIT_WORD && !r_key && r_gap_cnt >= CNT_W'(WORD_GAP_TICKS)) begin
         w_push      = 1'b1;
         w_push_data = CODE_W'(space_code(MAX_SYMBOLS));
      end
`endif
   end

   assign w_dropped = w_push && w_full && !(rd_en && !w_empty);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_press_cnt  <= '0;
         r_gap_cnt    <= '0;
         r_sym_cnt    <= '0;
         r_err_flag   <= 1'b0;
         r_live_code  <= '0;
         r_overflow   <= 1'b0;
         r_symbol_err <= 1'b0;
      end else begin
         r_symbol_err <= 1'b0;
         if (w_dropped) r_overflow <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (r_key) begin
                  r_state     <= ST_PRESS;
                  r_press_cnt <= '0;
               end
            end
            ST_PRESS: begin
               if (!r_key) begin
                  // A press shorter than one tick is a glitch and leaves the letter untouched.
                  if (r_press_cnt == '0) begin
                     r_state <= (r_sym_cnt == '0) ? ST_IDLE : ST_GAP;
                  end else begin
                     if (r_sym_cnt < SC_W'(MAX_SYMBOLS)) begin
                        r_live_code <= f_append(r_live_code, r_sym_cnt, w_sym);
                        r_sym_cnt   <= r_sym_cnt + 1'b1;
                     end else begin
                        r_err_flag  <= 1'b1;
                     end
                     r_state   <= ST_GAP;
                     r_gap_cnt <= '0;
                  end
               end else if (w_tick) begin
                  r_press_cnt <= f_sat_inc(r_press_cnt);
               end
            end
            ST_GAP: begin
               if (w_tick) r_gap_cnt <= f_sat_inc(r_gap_cnt);
               if (r_key) begin
                  r_state     <= ST_PRESS;
                  r_press_cnt <= '0;
               end else if (r_gap_cnt >= CNT_W'(LETTER_GAP_TICKS) || flush) begin
                  r_state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               // Gap count keeps running so the word gap is measured from the last release.
               if (w_tick) r_gap_cnt <= f_sat_inc(r_gap_cnt);
               r_symbol_err <= r_err_flag;
               r_live_code  <= '0;
               r_sym_cnt    <= '0;
               r_err_flag   <= 1'b0;
`ifdef MORSE_WORD_GAP_EN
               r_state      <= r_err_flag ? ST_IDLE : ST_WAIT_WORD;
`else
               r_state      <= ST_IDLE;
`endif
            end
`ifdef MORSE_WORD_GAP_EN
            ST_WAIT_WORD: begin
               if (w_tick) r_gap_cnt <= f_sat_inc(r_gap_cnt);
               if (r_key) begin
                  r_state     <= ST_PRESS;
                  r_press_cnt <= '0;
               end else if (r_gap_cnt >= CNT_W'(WORD_GAP_TICKS)) begin
                  r_state <= ST_IDLE;
               end
            end
`endif
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   morse_fifo #(
      .DATA_W (CODE_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_push),
      .i_pop     (rd_en),
      .i_wr_data (w_push_data),
      .o_rd_data (rd_data),
      .o_count   (fifo_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign rd_valid   = !w_empty;
   assign live_code  = r_live_code;
   assign overflow   = r_overflow;
   assign symbol_err = r_symbol_err;

endmodule

// File: tb/tb_morse_letter_capture.sv
// Scoreboard bench for morse_letter_capture: random letters against a symbol-list model.
module tb_morse_letter_capture;

   localparam int TICK_DIV = 4;
   localparam int DOT_MAX  = 3;
   localparam int LG       = 6;
   localparam int WG       = 14;
   localparam int MAXS     = 5;
   localparam int DEPTH    = 4;
   localparam int CW       = 2 * MAXS;
   localparam logic [CW-1:0] SPACE = '1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          key = 1'b0;
   logic          flush = 1'b0;
   logic          rd_en = 1'b0;
   logic [CW-1:0] rd_data;
   logic          rd_valid;
   logic [2:0]    fifo_count;
   logic [CW-1:0] live_code;
   logic          overflow;
   logic          symbol_err;

   morse_letter_capture #(
      .TICK_DIV(TICK_DIV), .DOT_MAX_TICKS(DOT_MAX), .LETTER_GAP_TICKS(LG),
      .WORD_GAP_TICKS(WG), .MAX_SYMBOLS(MAXS), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .key(key), .flush(flush), .rd_en(rd_en),
      .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
      .live_code(live_code), .overflow(overflow), .symbol_err(symbol_err)
   );

   always #5 clk = ~clk;

   logic [CW-1:0] exp_q [$];
   int  n_checks = 0;
   int  n_fails  = 0;
   int  exp_err  = 0;
   int  seen_err = 0;
   int  err_base = 0;
   bit  exp_ovf  = 1'b0;
   bit  auto_read = 1'b0;
   bit  last_ok  = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Letter code from the symbol list: symbol i occupies pair (MAXS-1-i), dot=1, dash=2.
   function automatic logic [CW-1:0] code_of(input int n, input logic [7:0] dash);
      int c;
      c = 0;
      for (int i = 0; i < n; i++) c += (dash[i] ? 2 : 1) * (1 << (2 * (MAXS - 1 - i)));
      return CW'(c);
   endfunction

   task automatic model_push(input logic [CW-1:0] code);
      if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
      else exp_q.push_back(code);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ticks(input int n);
      step(n * TICK_DIV);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key   = 1'b0;
      flush = 1'b0;
      rd_en = 1'b0;
      step(3);
      exp_q.delete();
      exp_ovf  = 1'b0;
      exp_err  = 0;
      err_base = seen_err;
      last_ok  = 1'b0;
      reset = 1'b0;
      step(1);
   endtask

   task automatic send_letter(input int n, input logic [7:0] dash, input bit by_flush,
                              input int gap_ticks);
      for (int i = 0; i < n; i++) begin
         key = 1'b1;
         ticks(dash[i] ? 5 + $urandom_range(0, 2) : 2 + $urandom_range(0, 1));
         key = 1'b0;
         if (i < n - 1) ticks(2 + $urandom_range(0, 1));
      end
      if (n > MAXS) begin
         exp_err++;
         last_ok = 1'b0;
      end else begin
         model_push(code_of(n, dash));
         last_ok = 1'b1;
      end
`ifdef MORSE_WORD_GAP_EN
      if (last_ok && gap_ticks >= WG + 4) model_push(SPACE);
`endif
      if (by_flush) begin
         ticks(1);
         flush = 1'b1;
         step(1);
         flush = 1'b0;
         ticks(gap_ticks - 1);
      end else begin
         ticks(gap_ticks);
      end
   endtask

   task automatic wait_drain(input int limit);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < limit) begin
         step(1);
         k++;
      end
      check("drain_timeout", exp_q.size(), 0);
      step(2);
      check("count_after_drain", int'(fifo_count), 0);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (symbol_err) seen_err++;
            if (rd_valid && rd_en) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fails++;
                  $display("FAIL pop_unexpected: got 0x%0h, expected no entry", rd_data);
               end else begin
                  check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
               end
            end
         end
         forever begin
            @(posedge clk);
            #1;
            if (auto_read) rd_en = rd_valid && ($urandom_range(0, 1) == 1);
         end
      join_none

      // Reset values
      do_reset();
      check("rst_rd_valid", int'(rd_valid), 0);
      check("rst_rd_data", int'(rd_data), 0);
      check("rst_fifo_count", int'(fifo_count), 0);
      check("rst_live_code", int'(live_code), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_symbol_err", int'(symbol_err), 0);

      // Dot then dash, closed by the letter gap
      begin
         int k;
         key = 1'b1; ticks(2); key = 1'b0; ticks(2);
         key = 1'b1; ticks(5); key = 1'b0;
         model_push(code_of(2, 8'b10));
         ticks(1);
         check("live_dot_dash", int'(live_code), int'(10'b0110_000000));
         check("no_early_valid", int'(rd_valid), 0);
         k = 0;
         while (!rd_valid && k < 40) begin
            step(1);
            k++;
         end
         check("valid_after_gap", int'(rd_valid), 1);
         check("count_one", int'(fifo_count), 1);
         check("live_cleared", int'(live_code), 0);
         rd_en = 1'b1; step(1); rd_en = 1'b0; step(1);
         check("count_after_pop", int'(fifo_count), 0);
      end

      // Six dots: too many symbols, letter discarded
      do_reset();
      send_letter(6, 8'h00, 1'b0, 8);
      check("symbol_err_pulses", seen_err - err_base, 1);
      check("err_fifo_empty", int'(fifo_count), 0);
      check("err_no_valid", int'(rd_valid), 0);

      // Sub-tick glitch yields nothing, next letter starts clean
      do_reset();
      key = 1'b1; step(1); key = 1'b0; step(4);
      check("glitch_live", int'(live_code), 0);
      ticks(8);
      check("glitch_no_push", int'(fifo_count), 0);
      auto_read = 1'b1;
      send_letter(1, 8'h01, 1'b0, 8);
      wait_drain(40);

      // Flush closes a letter at once
      do_reset();
      auto_read = 1'b0;
      rd_en = 1'b0;
      key = 1'b1; ticks(6); key = 1'b0;
      model_push(10'b1000_000000);
      ticks(1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      @(negedge clk);
      check("flush_commit_cycle_valid", int'(rd_valid), 0);
      @(negedge clk);
      check("flush_valid", int'(rd_valid), 1);
      check("flush_data", int'(rd_data), int'(10'b1000_000000));
      @(posedge clk);
      #1;
`ifdef MORSE_WORD_GAP_EN
      model_push(SPACE);
`endif
      auto_read = 1'b1;
      ticks(20);
      wait_drain(40);
      flush = 1'b1; step(1); flush = 1'b0;
      ticks(8);
      check("idle_flush_no_push", int'(fifo_count), 0);
      check("idle_flush_no_valid", int'(rd_valid), 0);

      // Five letters without reads overflow a depth-4 FIFO
      do_reset();
      auto_read = 1'b0;
      rd_en = 1'b0;
      for (int i = 0; i < 5; i++) send_letter(1 + i % 3, 8'($urandom), 1'b0, 8);
      check("full_count", int'(fifo_count), 4);
      check("overflow_set", int'(overflow), int'(exp_ovf));
      rd_en = 1'b1; step(4); rd_en = 1'b0; step(1);
      check("full_drained", int'(fifo_count), 0);

      // Push on full with a pop in the same cycle is not a drop
      do_reset();
      for (int i = 0; i < 4; i++) send_letter(1 + i % 2, 8'($urandom), 1'b0, 8);
      key = 1'b1; ticks(2); key = 1'b0;
      ticks(1);
      flush = 1'b1;
      step(1);
      flush = 1'b0;
      rd_en = 1'b1;
      step(1);
      rd_en = 1'b0;
      model_push(code_of(1, 8'h00));
      step(2);
      check("pop_push_overflow", int'(overflow), int'(exp_ovf));
      check("pop_push_count", int'(fifo_count), 4);
      rd_en = 1'b1; step(4); rd_en = 1'b0; step(1);
      check("pop_push_drained", int'(fifo_count), 0);

      // Random letters with random reads
      do_reset();
      auto_read = 1'b1;
      for (int i = 0; i < 12; i++) begin
         send_letter(($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(1, 5)),
                     8'($urandom), bit'($urandom_range(0, 1)), (i == 11) ? 20 : 8);
      end
      wait_drain(200);
      check("rand_symbol_err", seen_err - err_base, exp_err);
      check("rand_overflow", int'(overflow), int'(exp_ovf));

`ifdef MORSE_WORD_GAP_EN
      // One dot then long silence: letter followed by exactly one space
      do_reset();
      auto_read = 1'b0;
      rd_en = 1'b0;
      key = 1'b1; ticks(2); key = 1'b0;
      model_push(code_of(1, 8'h00));
      model_push(SPACE);
      ticks(20);
      check("word_gap_count", int'(fifo_count), 2);
      rd_en = 1'b1; step(2); rd_en = 1'b0; step(1);
      check("word_gap_drained", int'(fifo_count), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/morse_letter_capture.md
# morse_letter_capture

Timing-based Morse front end that replaces send-button letter framing. It measures the length of each debounced key press against a tick prescaler, classifies it as dot or dash, and closes a letter automatically after a configurable silence. Completed letters are pushed into an internal FIFO, which the decoder and text renderer drain at their own pace. It sits between the key debouncer and the letter decoder, in the 100 MHz `clk` domain.

## Interface
- `TICK_DIV`, 100000: `clk` cycles per timing tick (1 ms at 100 MHz); ≥2
- `DOT_MAX_TICKS`, 200: press of 1..DOT_MAX_TICKS ticks is a dot; longer is a dash
- `LETTER_GAP_TICKS`, 600: release length in ticks that closes a letter
- `WORD_GAP_TICKS`, 1400: release length in ticks that emits a word space (only with macro)
- `MAX_SYMBOLS`, 5: symbols per letter
- `FIFO_DEPTH`, 8: letter FIFO entries; power of 2, ≥2
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high; clears all state
- `key` in 1: debounced key, high = pressed
- `flush` in 1: 1-cycle pulse that closes the letter in progress immediately
- `rd_en` in 1: pop FIFO head; ignored when `rd_valid`=0
- `rd_data` out 2*MAX_SYMBOLS: FIFO head letter code, first-word-fall-through
- `rd_valid` out 1: FIFO not empty
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupancy
- `live_code` out 2*MAX_SYMBOLS: partial letter being keyed, for LEDs
- `overflow` out 1: sticky; a letter was dropped on a full FIFO
- `symbol_err` out 1: 1-cycle pulse when a letter exceeding MAX_SYMBOLS is discarded

## Operation
- Symbol encoding: 00 none, 01 dot, 10 dash. First symbol goes in bits [2*MAX_SYMBOLS-1 : 2*MAX_SYMBOLS-2], later symbols fill toward the LSB, and unused pairs are 00. Space code is all ones.
- `key` is registered once before use. The prescaler runs freely from reset and emits `tick` once every TICK_DIV cycles. Press and gap counters advance only on `tick` and saturate at all ones.
- FSM states:
  - IDLE: no letter in progress. Rising `key` goes to PRESS with press count 0.
  - PRESS: on falling `key`:
    - count 0 (glitch): no symbol; return to the prior state (IDLE if `sym_cnt`=0, else GAP).
    - otherwise classify the press. If `sym_cnt`<MAX_SYMBOLS, append the symbol and increment `sym_cnt`; if not, set `err_flag`. Then go to GAP with gap count 0.
  - GAP: rising `key` returns to PRESS in the same letter. A gap count reaching LETTER_GAP_TICKS, or `flush`=1, goes to COMMIT.
  - COMMIT: lasts one cycle.
    - If `err_flag`: pulse `symbol_err`, push nothing.
    - Otherwise push `live_code`.
    - Then clear `live_code`, `sym_cnt` and `err_flag`, and go to IDLE.
- `flush` in IDLE or PRESS is ignored.
- Push on a full FIFO is dropped and sets `overflow`, unless `rd_en` is asserted in the same cycle. In that case both the pop and the push succeed and the count is unchanged.
- Simultaneous push and pop on a non-full FIFO leaves `fifo_count` unchanged. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `fifo_count`=0, `live_code`=0, `overflow`=0, `symbol_err`=0. FSM is in IDLE and the prescaler is at 0.
- `key` edge to FSM reaction: 2 `clk` cycles (sync register plus state register).
- `live_code` updates on the cycle the FSM leaves PRESS.
- A push occurs in the COMMIT cycle. `rd_valid` and `fifo_count` update 1 cycle after COMMIT, and `rd_data` is valid with `rd_valid`.
- Pop: `rd_en` with `rd_valid` advances the head. The new `rd_data` and `fifo_count` appear on the next cycle.
- Reset mid-letter discards the partial letter and all FIFO contents.

## Configuration
- `MORSE_WORD_GAP_EN` defined:
  - After a successful COMMIT, the FSM enters WAIT_WORD.
  - `key` held low until WORD_GAP_TICKS (counted from the last release) pushes one space code and returns to IDLE.
  - A rising `key` first returns to PRESS with no space.
  - At most one space is pushed per silence. Space pushes follow the same FIFO full and `overflow` rules.
- Not defined: WAIT_WORD and WORD_GAP_TICKS logic are absent; COMMIT always returns to IDLE.

## Structure
- Package `morse_pkg`: SYM_NONE/SYM_DOT/SYM_DASH encodings, space-code function of MAX_SYMBOLS, FSM state enum.
- Sub-module `morse_fifo`: parametrised synchronous FWFT FIFO with count and full/empty. The FSM, prescaler and symbol assembly stay in the top block.

## Test plan
Bench parameters: TICK_DIV=4, DOT_MAX_TICKS=3, LETTER_GAP_TICKS=6, WORD_GAP_TICKS=14, MAX_SYMBOLS=5, FIFO_DEPTH=4.
- Press 2 ticks, release 2, press 5, release 7 → one entry 10'b0110_000000 (dot,dash); `rd_valid` high 1 cycle after COMMIT.
- Six dot presses separated by 2-tick gaps, then a 7-tick gap → `symbol_err` pulses once; FIFO stays empty.
- Key high for fewer than 4 `clk` cycles within one tick window (0 ticks) → no symbol; FSM back in IDLE; `live_code`=0.
- Five letters with no reads → `fifo_count`=4 and `overflow`=1. Repeat with `rd_en` held on the 5th COMMIT cycle → `overflow` stays 0 and count stays 4.
- One dash, then `flush` pulse after 1 gap tick → entry 10'b1000_000000 pushed immediately; `flush` in IDLE → no push.
- With `MORSE_WORD_GAP_EN`: one dot, then 20 ticks of silence → entries dot letter then 10'h3FF, exactly one space.
